// File: rtl/uart_pkg.sv
// Shared UART constants: baud_set encodings, TX/RX divider values and TX frame phases.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Transmit dividers: one bit lasts DIV+1 clocks at 50 MHz.
  localparam logic [15:0] TX_DIV_9600   = 16'd5207;
  localparam logic [15:0] TX_DIV_19200  = 16'd2603;
  localparam logic [15:0] TX_DIV_38400  = 16'd1301;
  localparam logic [15:0] TX_DIV_57600  = 16'd867;
  localparam logic [15:0] TX_DIV_115200 = 16'd433;

  // Receive-side dividers used by uart_byte_rx.
  localparam logic [15:0] RX_DIV_9600   = 16'd324;
  localparam logic [15:0] RX_DIV_19200  = 16'd162;
  localparam logic [15:0] RX_DIV_38400  = 16'd80;
  localparam logic [15:0] RX_DIV_57600  = 16'd53;
  localparam logic [15:0] RX_DIV_115200 = 16'd26;

  // Idle is carried by the busy flag, so the frame phase fits in two bits.
  typedef enum logic [1:0] {
    TX_START  = 2'd0,
    TX_DATA   = 2'd1,
    TX_PARITY = 2'd2,
    TX_STOP   = 2'd3
  } tx_phase_e;

  function automatic logic [15:0] tx_div(input logic [2:0] sel);
    logic [15:0] result;
    case (sel)
      BAUD_19200:  result = TX_DIV_19200;
      BAUD_38400:  result = TX_DIV_38400;
      BAUD_57600:  result = TX_DIV_57600;
      BAUD_115200: result = TX_DIV_115200;
      default:     result = TX_DIV_9600;
    endcase
    return result;
  endfunction

  function automatic logic tx_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick for one cycle each time the count reaches div.
// The count is held at zero while en is low so every frame starts a fresh period.
module uart_baud_tick (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en || cnt_q == div) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == div);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Line, busy flag and done pulse are all registered, so Rs232_Tx is glitch-free.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  input  logic [2:0] baud_set,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_phase_e            phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [15:0]          div_q, div_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick;

  uart_baud_tick u_baud_tick (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .en    (busy_q),
    .div   (div_q),
    .tick  (tick)
  );

  // The start bit goes out on the accept edge; every later bit changes only on tick.
  always_comb begin
    phase_d   = phase_q;
    busy_d    = busy_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    if (!busy_q) begin
      tx_d = 1'b1;
      if (send_en) begin
        busy_d    = 1'b1;
        phase_d   = TX_START;
        bit_cnt_d = '0;
        shift_d   = data_byte;
        div_d     = tx_div(baud_set);
        parity_d  = tx_parity(data_byte, PARITY_ODD);
        tx_d      = 1'b0;
      end
    end else if (tick) begin
      case (phase_q)
        TX_START: begin
          phase_d   = TX_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
        TX_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN) begin
              phase_d = TX_PARITY;
              tx_d    = parity_q;
            end else begin
              phase_d = TX_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
        TX_PARITY: begin
          phase_d = TX_STOP;
          tx_d    = 1'b1;
        end
        TX_STOP: begin
          phase_d = TX_START;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
        default: phase_d = TX_START;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase_q   <= TX_START;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign Rs232_Tx   = tx_q;
  assign Tx_Done    = done_q;
  assign uart_state = busy_q;

endmodule
